mul32_seq_ctrl: RTL and testbench



---
 rtl/mul_seq_pkg.sv | 17 +
 rtl/mul32x8_pp.sv | 15 +
 rtl/mul32_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_mul32_seq_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier controller.
package mul_seq_pkg;

    localparam int MUL_A_W    = 32;
    localparam int MUL_B_W    = 32;
    localparam int SLICE_W    = 8;
    localparam int NUM_SLICES = MUL_B_W / SLICE_W;
    localparam int PROD_W     = MUL_A_W + MUL_B_W;
    localparam int CNT_W      = $clog2(NUM_SLICES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul32x8_pp.sv
// Combinational A_W x SLICE_W unsigned partial-product array.
module mul32x8_pp #(
    parameter int A_W     = 32,
    parameter int SLICE_W = 8
) (
    input  logic [A_W-1:0]         a,
    input  logic [SLICE_W-1:0]     b,
    output logic [A_W+SLICE_W-1:0] p
);

    localparam int P_W = A_W + SLICE_W;

    assign p = P_W'(a) * P_W'(b);

endmodule

// File: rtl/mul32_seq_ctrl.sv
// Sequencer building a 32x32 unsigned product from four 32x8 partial products.
// Optional MUL32_SEQ_EARLY_TERM_EN: finish as soon as the remaining B slices are zero.
module mul32_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int A_W = MUL_A_W,
    parameter int B_W = MUL_B_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     in_a,
    input  logic [B_W-1:0]     in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] out_p,
    output logic               busy
);

    localparam int NSL = B_W / SLICE_W;
    localparam int PW  = A_W + B_W;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    mul_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [A_W-1:0]      a_q, a_d;
    logic [B_W-1:0]      b_q, b_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [PW-1:0]       out_p_q, out_p_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [SLICE_W-1:0]     b_slice;
    logic [A_W+SLICE_W-1:0] pp;
    logic [PW-1:0]          acc_sum;
    logic                   last_slice;

    // Partial-product array sees only captured operands, never the live inputs.
    assign b_slice = b_q[int'(cnt_q)*SLICE_W +: SLICE_W];

    mul32x8_pp #(
        .A_W     (A_W),
        .SLICE_W (SLICE_W)
    ) u_pp (
        .a (a_q),
        .b (b_slice),
        .p (pp)
    );

    assign acc_sum = acc_q + (PW'(pp) << (SLICE_W * int'(cnt_q)));

`ifdef MUL32_SEQ_EARLY_TERM_EN
    assign last_slice = (cnt_q == CW'(NSL - 1)) ||
                        ((b_q >> (SLICE_W * (int'(cnt_q) + 1))) == '0);
`else
    assign last_slice = (cnt_q == CW'(NSL - 1));
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        out_p_d     = out_p_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CW'(1);
                if (last_slice) begin
                    out_p_d     = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            out_p_q     <= out_p_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Self-checking bench for mul32_seq_ctrl: directed corner cases plus random operands.
module tb_mul32_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_p;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mul32_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Reference latency: with early termination the run stops after the
    // highest non-zero byte of B (at least one slice); otherwise always four.
    function automatic int ref_latency(input logic [31:0] b);
        int n;
        n = 4;
`ifdef MUL32_SEQ_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < 4; i++)
            if (((b >> (8 * i)) & 32'hFF) != 0) n = i + 1;
`endif
        return n;
    endfunction

    // One complete transaction: accept, measure latency, hold DONE for
    // 'hold' cycles with out_ready low while poking in_valid, then consume.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        logic [63:0] exp_p;
        int lat;
        exp_p = 64'(a) * 64'(b);
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(ref_latency(b)));
        check({tag, ".product"}, out_p, exp_p);
        check({tag, ".busy_done"}, 64'(busy), 64'd1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a     = 32'd7;
            in_b     = 32'd9;
            @(posedge clk);
            @(negedge clk);
            check({tag, ".bp_out_p"}, out_p, exp_p);
            check({tag, ".bp_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".bp_out_valid"}, 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".consumed_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".consumed_ready"}, 64'(in_ready), 64'd1);
        check({tag, ".out_p_kept"}, out_p, exp_p);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        #1;
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_p", out_p, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        check("max.const", out_p, 64'hFFFFFFFE00000001);
        do_op("carry1", 32'h0000FFFF, 32'h00010001, 0);
        check("carry1.const", out_p, 64'h00000000FFFFFFFF);
        do_op("carry2", 32'h00010000, 32'h00010000, 0);
        check("carry2.const", out_p, 64'h0000000100000000);
        do_op("bp", 32'd3, 32'd5, 3);
        check("bp.const", out_p, 64'hF);
        do_op("after_bp", 32'd7, 32'd9, 0);
        check("after_bp.const", out_p, 64'h3F);

        // Reset in the middle of RUN abandons the operation.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 32'h1234;
        in_b     = 32'h5678;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.out_valid", 64'(out_valid), 64'd0);
        check("midreset.busy", 64'(busy), 64'd0);
        check("midreset.in_ready", 64'(in_ready), 64'd1);
        check("midreset.out_p", out_p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_reset", 32'd2, 32'd3, 0);
        check("post_reset.const", out_p, 64'd6);

        do_op("low_b", 32'hDEADBEEF, 32'h000000FF, 0);
        do_op("zero_b", 32'hDEADBEEF, 32'h00000000, 0);
        check("zero_b.const", out_p, 64'd0);
        do_op("mid_b", 32'h89ABCDEF, 32'h00120000, 1);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) rb = rb & 32'h0000FFFF;
            if (i % 4 == 2) rb = rb & 32'h000000FF;
            do_op($sformatf("rand%0d", i), ra, rb, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
